// File: rtl/core_pkg.sv
// Shared widths, reset defaults and the fetch buffer entry type.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;

  // One buffered fetch: the address and the word the ROM returned for it.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush that empties it
// in one cycle. The caller must not push while full unless it also pops.
module fetch_buf
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wr_entry_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer/count/storage; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = wr_entry_i;
        tail_d        = tail_q + PW'(1);
      end
      if (pop_i) begin
        head_d = head_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the ROM, buffers returned words and
// hands instruction/PC pairs to decode. A redirect flushes and reloads the PC.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [XLEN-1:0]    rom_addr_o,
  input  logic [INSTR_W-1:0] rom_instr_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;
  logic            push;
  logic            pop;

  // valid_o depends only on registered count, so ready_i never reaches it.
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i & ~redirect_i;
  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign push    = ~redirect_i & ((count < CW'(DEPTH)) | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = rom_instr_i;

  // Next PC: redirect wins, otherwise advance only when the fetched word is kept.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + PC_INCR;
    end
  end

  // PC register; reset takes priority over any redirect in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (count)
  );

  assign rom_addr_o = pc_q;
  assign instr_o    = head.instr;
  assign pc_o       = head.pc;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly upstream of the instruction ROM and downstream of the core's redirect logic. It owns the program counter and drives the ROM address. It captures the ROM's combinational read data into a 2-entry buffer and presents instruction/PC pairs to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and reload the PC.

## Interface
Parameters:
- RESET_PC, 32'h0, PC value loaded on reset
- DEPTH, 2, output buffer entries (power of two, ≥2)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- rom_addr_o  out  32  fetch address to instruction ROM; equals pc_q combinationally
- rom_instr_i  in  32  ROM read data for rom_addr_o, valid in the same cycle
- valid_o  out  1  buffer head holds an instruction for decode
- ready_i  in  1  decode accepts the head this cycle
- instr_o  out  32  instruction at the buffer head
- pc_o  out  32  address of instr_o
- redirect_i  in  1  control-flow change from execute
- redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0

## Operation
- pop = valid_o & ready_i & ~redirect_i.
- push = ~redirect_i & (count < DEPTH | pop).
- A push writes {rom_addr_o, rom_instr_i} at the tail, and pc_q <= pc_q + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
- With no push and no redirect, pc_q holds.
- Redirect has the highest priority:
  - count <= 0 and all entries are invalidated.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - No push or pop occurs that cycle, regardless of ready_i.
- Push and pop together while full: count stays DEPTH, the head advances, and the new entry is written at the tail.
- Pop with no push: count decrements. Push with no pop: count increments.
- valid_o = (count != 0). instr_o and pc_o are taken from the head entry and are don't-care when valid_o = 0.
- The ROM's default word (32'hAAAA_AAAA) passes through unmodified; illegal-instruction detection belongs to decode.
- There is no explicit state machine. State is pc_q, count (clog2(DEPTH)+1 bits), and head/tail pointers that wrap modulo DEPTH.

## Timing
- Reset (rst_n = 0 at an edge):
  - pc_q = RESET_PC, count = 0, pointers = 0.
  - valid_o = 0, rom_addr_o = RESET_PC.
  - instr_o and pc_o = 0 (entry storage is reset).
- Reset asserted mid-operation discards all buffered entries at that edge; any redirect in the same cycle is ignored.
- Fetch-to-decode latency is 1 cycle. The word addressed in cycle N is at the head in cycle N+1 if the buffer was empty.
- Redirect in cycle N:
  - valid_o = 0 in cycle N+1.
  - rom_addr_o = target in cycle N+1.
  - The first target instruction is valid in cycle N+2.
- Throughput is 1 instruction/cycle while ready_i = 1.
- Backpressure is lossless. Once full with ready_i = 0, rom_addr_o holds at the next unfetched PC.
- There is a combinational path ready_i -> push -> pc enable; there is no path ready_i -> valid_o.

## Structure
- core_pkg holds:
  - XLEN = 32
  - INSTR_W = 32
  - RESET_PC default
  - PC_INCR = 4
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_buf is a parameterised DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head outputs, and synchronous active-low reset.
- instr_fetch is the PC register, push/pop/redirect control, and one fetch_buf instance.

## Test plan
- Reset, then ready_i = 1:
  - Cycle 0: rom_addr_o = 0x0, valid_o = 0.
  - Cycle 1: valid_o = 1, pc_o = 0x0, instr_o = 32'h0150_0093.
  - Cycle 2: pc_o = 0x4, instr_o = 32'h0FF0_0093.
- Backpressure, ready_i = 0 from reset:
  - count reaches 2 at cycle 2, and rom_addr_o holds at 0x8.
  - Raising ready_i then yields pc_o sequence 0x0, 0x4, 0x8, 0xC with no gaps or duplicates.
- Redirect to 0x13 in cycle 5 with ready_i = 1:
  - Cycle 6: valid_o = 0, rom_addr_o = 0x10.
  - Cycle 7: pc_o = 0x10, instr_o = 32'h01FF_C293.
- Redirect and ready_i = 1 in the same cycle with the buffer full: no entry is consumed, and the buffer is empty next cycle.
- PC wrap: redirect to 0xFFFF_FFFC, then ready_i = 1:
  - pc_o = 0xFFFF_FFFC with instr_o = 32'hAAAA_AAAA.
  - Next pc_o = 0x0.
- rst_n pulsed low for 1 cycle while full: valid_o = 0 and rom_addr_o = RESET_PC the next cycle.
